// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial pattern generator.
// The PAR state is only reachable when SEQ_GEN_PARITY_EN is defined.
package seq_gen_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEND = 3'd1,
      GAP  = 3'd2,
      DONE = 3'd3,
      PAR  = 3'd4
   } seq_state_t;

   localparam int unsigned DEF_MAX_LEN  = 8;
   localparam int unsigned DEF_CNT_W    = 4;
   localparam int unsigned DEF_GAP_BITS = 2;

   function automatic int unsigned seq_len_w(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, left-shift register; msb is the bit at the top of the loaded field,
// last is high once no further bits remain behind the one currently on the line.
module seq_piso #(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned LEN_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               shift,
   input  logic [MAX_LEN-1:0] data,
   input  logic [LEN_W-1:0]   cnt_init,
   output logic               msb,
   output logic               last
);

   logic [MAX_LEN-1:0] sr_q;
   logic [LEN_W-1:0]   cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (load) begin
         sr_q  <= data;
         cnt_q <= cnt_init;
      end else if (shift && (cnt_q != '0)) begin
         sr_q  <= sr_q << 1;
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign msb  = sr_q[MAX_LEN-1];
   assign last = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: MSB-first copies of a loaded word with zero gaps between them.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit to every copy.
module seq_pattern_gen
   import seq_gen_pkg::*;
#(
   parameter int unsigned MAX_LEN  = DEF_MAX_LEN,
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned GAP_BITS = DEF_GAP_BITS,
   localparam int unsigned LEN_W   = seq_len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   pat_len,
   input  logic [CNT_W-1:0]   repeat_cnt,
   output logic               outbits,
   output logic               bit_valid,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [2:0] S_IDLE = 3'(IDLE);
   localparam logic [2:0] S_SEND = 3'(SEND);
   localparam logic [2:0] S_GAP  = 3'(GAP);
   localparam logic [2:0] S_DONE = 3'(DONE);
   localparam logic [2:0] S_PAR  = 3'(PAR);
   localparam int unsigned GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

   // Left-justify the active field so its MSB sits at the top of the word.
   function automatic logic [MAX_LEN-1:0] align(input logic [MAX_LEN-1:0] p,
                                                input logic [LEN_W-1:0]   l);
      return p << (MAX_LEN - int'(l));
   endfunction

   logic [2:0]         state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   copies_q, copies_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               outbits_q, bit_d;
   logic               valid_q, valid_d;
   logic               busy_q, done_q, err_q, err_d;
   logic [MAX_LEN-1:0] src_pat, first;
   logic [LEN_W-1:0]   src_len;
   logic               len_ok, copy_end, copy_start, shift;
   logic               piso_msb, piso_last;
`ifdef SEQ_GEN_PARITY_EN
   logic               par_q, par_d;
`endif

   assign len_ok  = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
   assign src_pat = (state_q == S_IDLE) ? pattern : pat_q;
   assign src_len = (state_q == S_IDLE) ? pat_len : len_q;
   assign first   = align(src_pat, src_len);

   // The first bit of a copy is emitted straight from the aligned word; the
   // shifter is loaded with the remainder so it is always one bit ahead.
   seq_piso #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_piso (
      .clk      (clk),
      .reset    (reset),
      .load     (copy_start),
      .shift    (shift),
      .data     (first << 1),
      .cnt_init (src_len - 1'b1),
      .msb      (piso_msb),
      .last     (piso_last)
   );

   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      len_d      = len_q;
      copies_d   = copies_q;
      gap_d      = gap_q;
      bit_d      = 1'b0;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      shift      = 1'b0;
      copy_end   = 1'b0;
      copy_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len_ok) begin
                  pat_d      = pattern;
                  len_d      = pat_len;
                  copies_d   = repeat_cnt;
                  copy_start = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_SEND: begin
            if (!piso_last) begin
               bit_d   = piso_msb;
               valid_d = 1'b1;
               shift   = 1'b1;
            end else begin
`ifdef SEQ_GEN_PARITY_EN
               state_d = S_PAR;
               bit_d   = par_q;
               valid_d = 1'b1;
`else
               copy_end = 1'b1;
`endif
            end
         end
`ifdef SEQ_GEN_PARITY_EN
         S_PAR: copy_end = 1'b1;
`endif
         S_GAP: begin
            if (gap_q == '0) copy_start = 1'b1;
            else             gap_d      = gap_q - 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (copy_end) begin
         if (copies_q == '0) begin
            state_d = S_DONE;
         end else if (GAP_BITS > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_W'(GAP_BITS - 1);
         end else begin
            copy_start = 1'b1;
         end
      end

      if (copy_start) begin
         state_d = S_SEND;
         bit_d   = first[MAX_LEN-1];
         valid_d = 1'b1;
         if (state_q != S_IDLE) copies_d = copies_q - 1'b1;
      end
   end

`ifdef SEQ_GEN_PARITY_EN
   always_comb begin
      par_d = par_q;
      if ((state_q == S_IDLE) && copy_start) par_d = ^first;
   end

   always_ff @(posedge clk) begin
      if (reset) par_q <= 1'b0;
      else       par_q <= par_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pat_q     <= '0;
         len_q     <= '0;
         copies_q  <= '0;
         gap_q     <= '0;
         outbits_q <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         len_q     <= len_d;
         copies_q  <= copies_d;
         gap_q     <= gap_d;
         outbits_q <= bit_d;
         valid_q   <= valid_d;
         busy_q    <= (state_d != S_IDLE);
         done_q    <= (state_d == S_DONE);
         err_q     <= err_d;
      end
   end

   assign outbits   = outbits_q;
   assign bit_valid = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
